// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: one req/ack data-memory transaction per load/store, pipeline frozen meanwhile.
// Optional watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_stage_ctrl #(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t state_q, state_d;
   logic   op;
   logic   timeout;

   assign op = mem_read_i | mem_write_i;

   if (TIMEOUT_W < 1) begin : g_bad_timeout_w
      $error("mem_stage_ctrl: TIMEOUT_W must be at least 1");
   end

`ifdef MEM_CTRL_TIMEOUT_EN
   // Timeout fires on the wait cycle that would bring the counter to all-ones.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   logic [TIMEOUT_W-1:0] wd_cnt_q;
   logic                 err_q;

   assign timeout = (state_q == WAIT) && !dmem_ack_i && (wd_cnt_q == TO_LAST);
   assign err_o   = err_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == IDLE && op)
            wd_cnt_q <= '0;
         else if (state_q == WAIT && !dmem_ack_i)
            wd_cnt_q <= wd_cnt_q + 1'b1;
         if (timeout)
            err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o = op;
            if (op)
               state_d = WAIT;
         end
         WAIT: begin
            stall_o = 1'b1;
            if (dmem_ack_i || timeout)
               state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request registers and load-data capture; a read+write combination is issued as a write.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         rdata_o      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op) begin
                  dmem_req_o   <= 1'b1;
                  dmem_we_o    <= mem_write_i;
                  dmem_addr_o  <= addr_i;
                  dmem_wdata_o <= wdata_i;
               end
            end
            WAIT: begin
               if (dmem_ack_i) begin
                  dmem_req_o <= 1'b0;
                  if (!dmem_we_o)
                     rdata_o <= dmem_rdata_i;
               end else if (timeout) begin
                  dmem_req_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, back-to-back ops, idle, reset mid-wait, watchdog.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_read_i, mem_write_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;

   int checks   = 0;
   int failures = 0;

   mem_stage_ctrl #(.TIMEOUT_W(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .stall_o      (stall_o),
      .rdata_o      (rdata_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL sim_timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

   // Start a new cycle: inputs are driven just after the rising edge.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      addr_i = '0; wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;

      // Reset state
      next_cycle(); next_cycle(); settle();
      chk1 ("rst_req",   dmem_req_o, 1'b0);
      chk1 ("rst_we",    dmem_we_o,  1'b0);
      chk32("rst_addr",  dmem_addr_o,  32'h0);
      chk32("rst_wdata", dmem_wdata_o, 32'h0);
      chk32("rst_rdata", rdata_o, 32'h0);
      chk1 ("rst_done",  done_o,  1'b0);
      chk1 ("rst_err",   err_o,   1'b0);
      chk1 ("rst_stall", stall_o, 1'b0);

      // Load, ack three cycles after the request rises
      next_cycle(); rst_i = 1'b1;
      next_cycle(); mem_read_i = 1'b1; addr_i = 32'h10; dmem_rdata_i = 32'hDEAD_BEEF; settle();
      chk1 ("ld_c0_stall", stall_o, 1'b1);
      chk1 ("ld_c0_req",   dmem_req_o, 1'b0);
      next_cycle(); settle();
      chk1 ("ld_c1_req",   dmem_req_o, 1'b1);
      chk1 ("ld_c1_we",    dmem_we_o,  1'b0);
      chk32("ld_c1_addr",  dmem_addr_o, 32'h10);
      chk1 ("ld_c1_stall", stall_o, 1'b1);
      next_cycle(); settle();
      chk1 ("ld_c2_stall", stall_o, 1'b1);
      next_cycle(); settle();
      chk1 ("ld_c3_stall", stall_o, 1'b1);
      chk1 ("ld_c3_done",  done_o,  1'b0);
      next_cycle(); dmem_ack_i = 1'b1; settle();
      chk1 ("ld_c4_stall", stall_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0BAD_0BAD; settle();
      chk1 ("ld_c5_done",  done_o,  1'b1);
      chk1 ("ld_c5_stall", stall_o, 1'b0);
      chk1 ("ld_c5_req",   dmem_req_o, 1'b0);
      chk32("ld_c5_rdata", rdata_o, 32'hDEAD_BEEF);
      next_cycle(); mem_read_i = 1'b0; settle();
      chk1 ("ld_c6_done",  done_o,  1'b0);
      chk1 ("ld_c6_stall", stall_o, 1'b0);
      chk32("ld_c6_rdata", rdata_o, 32'hDEAD_BEEF);

      // Store, acked in the first request cycle
      next_cycle(); mem_write_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678;
      dmem_rdata_i = 32'hCAFE_F00D; settle();
      chk1 ("st_c0_stall", stall_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b1; settle();
      chk1 ("st_c1_req",   dmem_req_o, 1'b1);
      chk1 ("st_c1_we",    dmem_we_o,  1'b1);
      chk32("st_c1_addr",  dmem_addr_o,  32'h20);
      chk32("st_c1_wdata", dmem_wdata_o, 32'h1234_5678);
      chk1 ("st_c1_stall", stall_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b0; settle();
      chk1 ("st_c2_done",  done_o,  1'b1);
      chk1 ("st_c2_stall", stall_o, 1'b0);
      chk32("st_c2_rdata", rdata_o, 32'hDEAD_BEEF);
      next_cycle(); mem_write_i = 1'b0; settle();
      chk1 ("st_c3_stall", stall_o, 1'b0);

      // Back-to-back loads; the old instruction is still presented during DONE
      next_cycle(); mem_read_i = 1'b1; addr_i = 32'h4; settle();
      chk1 ("bb_a_c0_stall", stall_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_1111; settle();
      chk1 ("bb_a_c1_req",  dmem_req_o, 1'b1);
      chk32("bb_a_c1_addr", dmem_addr_o, 32'h4);
      next_cycle(); dmem_ack_i = 1'b0; settle();
      chk1 ("bb_a_done",   done_o,  1'b1);
      chk1 ("bb_a_stall",  stall_o, 1'b0);
      chk1 ("bb_a_req",    dmem_req_o, 1'b0);
      chk32("bb_a_rdata",  rdata_o, 32'h1111_1111);
      next_cycle(); addr_i = 32'h8; settle();
      chk1 ("bb_b_c0_stall", stall_o, 1'b1);
      chk1 ("bb_b_c0_req",   dmem_req_o, 1'b0);
      next_cycle(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h2222_2222; settle();
      chk1 ("bb_b_c1_req",  dmem_req_o, 1'b1);
      chk32("bb_b_c1_addr", dmem_addr_o, 32'h8);
      next_cycle(); dmem_ack_i = 1'b0; settle();
      chk1 ("bb_b_done",  done_o, 1'b1);
      chk32("bb_b_rdata", rdata_o, 32'h2222_2222);
      next_cycle(); mem_read_i = 1'b0; settle();
      chk1 ("bb_after_stall", stall_o, 1'b0);
      chk1 ("bb_after_req",   dmem_req_o, 1'b0);

      // Non-memory instructions with a stray ack: no stall, no request
      dmem_ack_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next_cycle(); settle();
         chk1 ("nomem_stall", stall_o, 1'b0);
         chk1 ("nomem_req",   dmem_req_o, 1'b0);
         chk1 ("nomem_done",  done_o, 1'b0);
      end
      dmem_ack_i = 1'b0;

      // Read and write both set: issued as a write, no read data captured
      next_cycle(); mem_read_i = 1'b1; mem_write_i = 1'b1; addr_i = 32'h24;
      wdata_i = 32'hA5A5_5A5A; dmem_rdata_i = 32'h3333_3333; settle();
      next_cycle(); dmem_ack_i = 1'b1; settle();
      chk1 ("rw_we", dmem_we_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b0; settle();
      chk1 ("rw_done",  done_o, 1'b1);
      chk32("rw_rdata", rdata_o, 32'h2222_2222);
      next_cycle(); mem_read_i = 1'b0; mem_write_i = 1'b0;

      // Reset asserted on the second WAIT cycle
      next_cycle(); mem_read_i = 1'b1; addr_i = 32'h30; wdata_i = 32'h55; settle();
      next_cycle(); settle();
      chk1 ("rw1_req", dmem_req_o, 1'b1);
      next_cycle(); rst_i = 1'b0; mem_read_i = 1'b0; settle();
      chk1 ("rw2_req", dmem_req_o, 1'b1);
      next_cycle(); rst_i = 1'b1; settle();
      chk1 ("mrst_req",   dmem_req_o, 1'b0);
      chk1 ("mrst_stall", stall_o, 1'b0);
      chk1 ("mrst_we",    dmem_we_o, 1'b0);
      chk32("mrst_addr",  dmem_addr_o, 32'h0);
      chk32("mrst_wdata", dmem_wdata_o, 32'h0);
      chk32("mrst_rdata", rdata_o, 32'h0);
      chk1 ("mrst_done",  done_o, 1'b0);
      next_cycle(); settle();
      chk1 ("mrst_idle_stall", stall_o, 1'b0);
      chk1 ("mrst_idle_done",  done_o, 1'b0);

      // Load never acked within the watchdog window
      next_cycle(); mem_read_i = 1'b1; addr_i = 32'h40; dmem_rdata_i = 32'h7777_7777; settle();
      for (int i = 1; i <= 15; i++) begin
         next_cycle(); settle();
         chk1 ("lw_req",   dmem_req_o, 1'b1);
         chk1 ("lw_err",   err_o, 1'b0);
         chk1 ("lw_stall", stall_o, 1'b1);
      end
      next_cycle(); settle();
`ifdef MEM_CTRL_TIMEOUT_EN
      chk1 ("to_done",  done_o, 1'b1);
      chk1 ("to_err",   err_o, 1'b1);
      chk1 ("to_req",   dmem_req_o, 1'b0);
      chk32("to_rdata", rdata_o, 32'h0);
      next_cycle(); mem_read_i = 1'b0; settle();
      chk1 ("to_err_hold",  err_o, 1'b1);
      chk1 ("to_idle_stall", stall_o, 1'b0);
      next_cycle(); rst_i = 1'b0; settle();
      next_cycle(); rst_i = 1'b1; settle();
      chk1 ("to_err_clr", err_o, 1'b0);
`else
      chk1 ("nowd_req",   dmem_req_o, 1'b1);
      chk1 ("nowd_done",  done_o, 1'b0);
      chk1 ("nowd_err",   err_o, 1'b0);
      for (int i = 0; i < 5; i++) next_cycle();
      dmem_ack_i = 1'b1; settle();
      chk1 ("nowd_late_stall", stall_o, 1'b1);
      next_cycle(); dmem_ack_i = 1'b0; settle();
      chk1 ("nowd_done2", done_o, 1'b1);
      chk32("nowd_rdata", rdata_o, 32'h7777_7777);
      next_cycle(); mem_read_i = 1'b0; settle();
      chk1 ("nowd_idle_stall", stall_o, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
